// File: rtl/convolve_pkg.sv
// Shared types and the pixel scaling helper for the convolution result writer.
package convolve_pkg;

   typedef enum logic [1:0] {
      S_idle,
      S_run,
      S_done
   } state_t;

   localparam int PIX_MAX = 255;

   // Arithmetic shift, then clamp to the unsigned 8-bit pixel range.
   function automatic logic [7:0] sat_pixel(input logic signed [47:0] i_val,
                                            input int unsigned         i_shift);
      logic signed [47:0] w_s;
      w_s = i_val >>> i_shift;
      if (w_s < 48'sd0)
         return 8'd0;
      else if (w_s > 48'sd255)
         return PIX_MAX[7:0];
      else
         return w_s[7:0];
   endfunction

endpackage

// File: rtl/frame_raster_counter.sv
// Raster-order pixel counter: column, row and a running linear address,
// plus border/last-pixel classification of the current coordinate.
module frame_raster_counter #(
   parameter int WIDTH       = 640,
   parameter int HEIGHT      = 480,
   parameter int KERNEL_SIZE = 3,
   parameter int ADDR_W      = 19
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_init,
   input  logic              i_advance,
   output logic [31:0]       o_w,
   output logic [31:0]       o_h,
   output logic [ADDR_W-1:0] o_addr,
   output logic              o_is_border,
   output logic              o_is_last
);

   localparam int M = KERNEL_SIZE / 2;

   logic [31:0]       r_w;
   logic [31:0]       r_h;
   logic [ADDR_W-1:0] r_addr;

   // Step through the frame; the address simply increments since raster
   // order makes h*WIDTH+w contiguous.
   always_ff @(posedge clk) begin
      if (reset || i_init) begin
         r_w    <= '0;
         r_h    <= '0;
         r_addr <= '0;
      end else if (i_advance) begin
         r_addr <= r_addr + ADDR_W'(1);
         if (r_w == WIDTH - 1) begin
            r_w <= '0;
            r_h <= r_h + 32'd1;
         end else begin
            r_w <= r_w + 32'd1;
         end
      end
   end

   assign o_w         = r_w;
   assign o_h         = r_h;
   assign o_addr      = r_addr;
   assign o_is_border = (r_w < M) || (r_w >= WIDTH - M) ||
                        (r_h < M) || (r_h >= HEIGHT - M);
   assign o_is_last   = (r_w == WIDTH - 1) && (r_h == HEIGHT - 1);

endmodule

// File: rtl/convolve_result_writer.sv
// Sink of the convolution scan: writes one 8-bit pixel per frame position,
// zero on the border, scaled/saturated convolution results in the interior.
module convolve_result_writer
   import convolve_pkg::*;
#(
   parameter int WIDTH       = 640,
   parameter int HEIGHT      = 480,
   parameter int KERNEL_SIZE = 3,
   parameter int SHIFT       = 0,
   parameter int ADDR_W      = 19
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic signed [47:0] in_data,
   input  logic [31:0]        in_w,
   input  logic [31:0]        in_h,
   output logic               mem_we,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [7:0]         mem_wdata,
   output logic               busy,
   output logic               done,
   output logic               error
);

   state_t            r_state;
   logic              r_vld_p1;
   logic [ADDR_W-1:0] r_addr_p1;
   logic [7:0]        r_data_p1;
   logic              r_done;
   logic              r_error;

   logic [31:0]       w_w;
   logic [31:0]       w_h;
   logic [ADDR_W-1:0] w_addr;
   logic              w_is_border;
   logic              w_is_last;
   logic              w_run;
   logic              w_hs;
   logic              w_advance;
   logic              w_init;
   logic              w_tag_bad;
   logic [7:0]        w_pixel;

   frame_raster_counter #(
      .WIDTH       (WIDTH),
      .HEIGHT      (HEIGHT),
      .KERNEL_SIZE (KERNEL_SIZE),
      .ADDR_W      (ADDR_W)
   ) u_cnt (
      .clk         (clk),
      .reset       (reset),
      .i_init      (w_init),
      .i_advance   (w_advance),
      .o_w         (w_w),
      .o_h         (w_h),
      .o_addr      (w_addr),
      .o_is_border (w_is_border),
      .o_is_last   (w_is_last)
   );

   // Border pixels never wait for input; interior pixels wait for a result.
   assign w_run     = (r_state == S_run);
   assign in_ready  = w_run && !w_is_border;
   assign w_hs      = in_ready && in_valid;
   assign w_advance = w_run && (w_is_border || in_valid);
   assign w_init    = (r_state != S_run) && start;
   assign w_tag_bad = (in_w != w_w) || (in_h != w_h);
   assign w_pixel   = w_is_border ? 8'd0 : sat_pixel(in_data, int'(SHIFT));

   // Writer FSM with the registered write port (stage p0 -> p1).
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_idle;
         r_vld_p1  <= 1'b0;
         r_addr_p1 <= '0;
         r_data_p1 <= '0;
         r_done    <= 1'b0;
         r_error   <= 1'b0;
      end else begin
         case (r_state)
            S_idle, S_done: begin
               r_vld_p1 <= 1'b0;
               if (start) begin
                  r_state <= S_run;
                  r_done  <= 1'b0;
                  r_error <= 1'b0;
               end
            end
            S_run: begin
               r_vld_p1 <= w_advance;
               if (w_advance) begin
                  r_addr_p1 <= w_addr;
                  r_data_p1 <= w_pixel;
               end
               if (w_hs && w_tag_bad)
                  r_error <= 1'b1;
               if (w_advance && w_is_last) begin
                  r_state <= S_done;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= S_idle;
         endcase
      end
   end

   assign mem_we    = r_vld_p1;
   assign mem_addr  = r_addr_p1;
   assign mem_wdata = r_data_p1;
   assign busy      = w_run;
   assign done      = r_done;
   assign error     = r_error;

endmodule

// File: tb/tb_convolve_result_writer.sv
// Directed bench for convolve_result_writer on a 5x5 frame, 3x3 kernel.
// Two instances share the stimulus: SHIFT=0 and SHIFT=2.
module tb_convolve_result_writer;

   localparam int FW = 5;
   localparam int FH = 5;
   localparam int AW = 5;

   logic               clk = 1'b0;
   logic               reset;
   logic               start;
   logic               in_valid;
   logic signed [47:0] in_data;
   logic [31:0]        in_w;
   logic [31:0]        in_h;

   logic          in_ready,  mem_we,  busy,  done,  error;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wdata;
   logic          in_ready2, mem_we2, busy2, done2, error2;
   logic [AW-1:0] mem_addr2;
   logic [7:0]    mem_wdata2;

   always #5 clk = ~clk;

   convolve_result_writer #(.WIDTH(FW), .HEIGHT(FH), .KERNEL_SIZE(3), .SHIFT(0), .ADDR_W(AW)) u_dut (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_w(in_w), .in_h(in_h), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .busy(busy), .done(done), .error(error));

   convolve_result_writer #(.WIDTH(FW), .HEIGHT(FH), .KERNEL_SIZE(3), .SHIFT(2), .ADDR_W(AW)) u_dut2 (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready2),
      .in_data(in_data), .in_w(in_w), .in_h(in_h), .mem_we(mem_we2), .mem_addr(mem_addr2),
      .mem_wdata(mem_wdata2), .busy(busy2), .done(done2), .error(error2));

   int n_cmp = 0;
   int n_fail = 0;

   logic [7:0] img0 [0:31];
   logic [7:0] img2 [0:31];
   int         wr_cnt;
   int         first_addr;
   logic       done_at_last;
   int         rdy_stall;

   int fw [9];
   int fh [9];
   int fd [9];

   typedef struct {
      int addr;
      int exp0;
      int exp2;
   } vec_t;

   vec_t tab_a [15];
   vec_t tab_s [9];

   // Capture memory writes of both instances.
   always @(negedge clk) begin
      if (mem_we) begin
         if (wr_cnt == 0) first_addr = int'(mem_addr);
         img0[mem_addr] = mem_wdata;
         wr_cnt = wr_cnt + 1;
         if (int'(mem_addr) == FW * FH - 1) done_at_last = done;
      end
      if (mem_we2) img2[mem_addr2] = mem_wdata2;
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive_inputs(input int idx, input int stall_idx, input int stall);
      if (idx < 9) begin
         in_w     = 32'(fw[idx]);
         in_h     = 32'(fh[idx]);
         in_data  = 48'(fd[idx]);
         in_valid = !(idx == stall_idx && stall > 0);
      end else begin
         in_valid = 1'b0;
      end
   endtask

   task automatic set_normal_feed();
      for (int i = 0; i < 9; i++) begin
         fw[i] = 1 + i % 3;
         fh[i] = 1 + i / 3;
         fd[i] = 10 * fh[i] + fw[i];
      end
   endtask

   task automatic check_outputs_zero(input string name);
      check({name, "_dut0"}, int'({mem_we, mem_addr, mem_wdata, busy, done, error, in_ready}), 0);
      check({name, "_dut2"}, int'({mem_we2, mem_addr2, mem_wdata2, busy2, done2, error2, in_ready2}), 0);
   endtask

   // Run one frame: start pulse, feed the 9 interior results, wait for done.
   task automatic run_frame(input int stall_idx, input int stall_len, input int mid_start,
                            input int abort_at, output int cycles);
      int   idx;
      int   stall;
      int   saved;
      logic hs;
      for (int i = 0; i < 32; i++) begin
         img0[i] = 8'hAA;
         img2[i] = 8'hAA;
      end
      wr_cnt = 0; first_addr = -1; done_at_last = 1'b0; rdy_stall = 0;
      in_valid = 1'b0;
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_after_start", int'(busy), 1);
      check("done_after_start", int'(done), 0);
      idx = 0; stall = stall_len; cycles = 0;
      drive_inputs(idx, stall_idx, stall);
      while (cycles < 200) begin
         @(negedge clk);
         hs = in_valid && in_ready;
         if (idx == stall_idx && stall > 0 && in_ready) begin
            stall--;
            rdy_stall++;
         end
         if (mid_start == cycles) start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         cycles++;
         if (hs) idx++;
         if (abort_at > 0 && wr_cnt >= abort_at) begin
            reset = 1'b1;
            in_valid = 1'b0;
            @(posedge clk); #1;
            check_outputs_zero("reset_mid_frame");
            reset = 1'b0;
            saved = wr_cnt;
            repeat (3) @(posedge clk);
            #1;
            check("no_write_after_reset", wr_cnt, saved);
            check("idle_after_reset_busy", int'(busy), 0);
            return;
         end
         if (done) break;
         drive_inputs(idx, stall_idx, stall);
      end
      if (cycles >= 200) check("frame_timeout", cycles, -1);
      in_valid = 1'b0;
      @(negedge clk); #1;
   endtask

   task automatic check_table_a(input string name);
      for (int i = 0; i < 15; i++) begin
         check($sformatf("%s_a%0d_s0", name, tab_a[i].addr), int'(img0[tab_a[i].addr]), tab_a[i].exp0);
         check($sformatf("%s_a%0d_s2", name, tab_a[i].addr), int'(img2[tab_a[i].addr]), tab_a[i].exp2);
      end
   endtask

   initial begin
      int cyc;
      // Frame image sample: {addr, SHIFT=0 value, SHIFT=2 value}
      tab_a[0]  = '{0, 0, 0};   tab_a[1]  = '{1, 0, 0};   tab_a[2]  = '{4, 0, 0};
      tab_a[3]  = '{5, 0, 0};   tab_a[4]  = '{6, 11, 2};  tab_a[5]  = '{7, 12, 3};
      tab_a[6]  = '{8, 13, 3};  tab_a[7]  = '{9, 0, 0};   tab_a[8]  = '{11, 21, 5};
      tab_a[9]  = '{12, 22, 5}; tab_a[10] = '{13, 23, 5}; tab_a[11] = '{16, 31, 7};
      tab_a[12] = '{18, 33, 8}; tab_a[13] = '{20, 0, 0};  tab_a[14] = '{24, 0, 0};
      // Saturation: data fed in raster order to interior addresses
      tab_s[0] = '{6, 0, 0};     tab_s[1] = '{7, 255, 255}; tab_s[2] = '{8, 255, 255};
      tab_s[3] = '{11, 100, 25}; tab_s[4] = '{12, 0, 0};    tab_s[5] = '{13, 255, 63};
      tab_s[6] = '{16, 255, 64}; tab_s[7] = '{17, 0, 0};    tab_s[8] = '{18, 7, 1};

      set_normal_feed();
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; in_w = '0; in_h = '0;
      wr_cnt = 0; first_addr = -1; done_at_last = 1'b0; rdy_stall = 0;
      repeat (2) @(posedge clk);
      #1;
      check_outputs_zero("reset_state");
      reset = 1'b0;

      // Plain frame
      run_frame(-1, 0, -1, 0, cyc);
      check("A_cycles", cyc, 25);
      check("A_writes", wr_cnt, 25);
      check("A_first_addr", first_addr, 0);
      check("A_done_with_last_write", int'(done_at_last), 1);
      check("A_done", int'(done), 1);
      check("A_busy", int'(busy), 0);
      check("A_error", int'(error), 0);
      check_table_a("A");

      // Three stall cycles before pixel (2,2)
      run_frame(4, 3, -1, 0, cyc);
      check("B_cycles", cyc, 28);
      check("B_writes", wr_cnt, 25);
      check("B_ready_during_stall", rdy_stall, 3);
      check("B_done", int'(done), 1);
      check_table_a("B");

      // Saturation
      fd[0] = -5; fd[1] = 1023; fd[2] = 1020; fd[3] = 100; fd[4] = 0;
      fd[5] = 255; fd[6] = 256; fd[7] = -1; fd[8] = 7;
      run_frame(-1, 0, -1, 0, cyc);
      check("C_writes", wr_cnt, 25);
      for (int i = 0; i < 9; i++) begin
         check($sformatf("C_sat_a%0d_s0", tab_s[i].addr), int'(img0[tab_s[i].addr]), tab_s[i].exp0);
         check($sformatf("C_sat_a%0d_s2", tab_s[i].addr), int'(img2[tab_s[i].addr]), tab_s[i].exp2);
      end
      set_normal_feed();

      // Misordered first interior tag
      fw[0] = 2;
      run_frame(-1, 0, -1, 0, cyc);
      check("D_error_sticky", int'(error), 1);
      check("D_addr6", int'(img0[6]), 11);
      check("D_done", int'(done), 1);
      check("D_writes", wr_cnt, 25);
      set_normal_feed();

      // Start from S_done clears error; start pulsed mid-frame is ignored
      run_frame(-1, 0, 10, 0, cyc);
      check("E_cycles", cyc, 25);
      check("E_writes", wr_cnt, 25);
      check("E_error_cleared", int'(error), 0);
      check("E_done", int'(done), 1);
      check_table_a("E");

      // Reset after 12 writes, then a fresh full frame
      run_frame(-1, 0, -1, 12, cyc);
      run_frame(-1, 0, -1, 0, cyc);
      check("G_cycles", cyc, 25);
      check("G_writes", wr_cnt, 25);
      check("G_first_addr", first_addr, 0);
      check("G_done", int'(done), 1);
      check_table_a("G");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, limit reached");
      $fatal(1, "timeout");
   end

endmodule
